// File: rtl/lnrv_biu_arb.sv
// ============================================================================
//  Module      : lnrv_biu_arb
//  Description : Two-requester bus arbiter (m0 = LSU, m1 = IFU) sharing one
//                core memory port. Round-robin grant with zero-latency command
//                pass-through, in-order response routing through an ID FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lnrv_biu_arb #(
    parameter int OTS_DEPTH = 2,
    parameter int OTS_W     = 2
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_cmd_vld,
    output logic        m0_cmd_rdy,
    input  logic        m0_cmd_write,
    input  logic [31:0] m0_cmd_addr,
    input  logic [31:0] m0_cmd_wdata,
    input  logic [3:0]  m0_cmd_wstrb,
    output logic        m0_rsp_vld,
    input  logic        m0_rsp_rdy,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_cmd_vld,
    output logic        m1_cmd_rdy,
    input  logic        m1_cmd_write,
    input  logic [31:0] m1_cmd_addr,
    input  logic [31:0] m1_cmd_wdata,
    input  logic [3:0]  m1_cmd_wstrb,
    output logic        m1_rsp_vld,
    input  logic        m1_rsp_rdy,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,

    output logic        bus_cmd_vld,
    input  logic        bus_cmd_rdy,
    output logic        bus_cmd_write,
    output logic [31:0] bus_cmd_addr,
    output logic [31:0] bus_cmd_wdata,
    output logic [3:0]  bus_cmd_wstrb,
    input  logic        bus_rsp_vld,
    output logic        bus_rsp_rdy,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err,

    output logic [OTS_W-1:0] ots_cnt,
    output logic        rsp_orphan
);

    localparam int               PTR_W    = (OTS_DEPTH > 1) ? $clog2(OTS_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OTS_DEPTH - 1);
    localparam logic [OTS_W-1:0] OTS_FULL = OTS_W'(OTS_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]           state_q,    state_d;
    logic                 gnt_q,      gnt_d;
    logic                 last_gnt_q, last_gnt_d;
    logic [OTS_W-1:0]     ots_cnt_q,  ots_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [OTS_DEPTH-1:0] id_q,       id_d;

    logic fifo_empty;
    logic fifo_full;
    logic sel;
    logic gnt_act;
    logic cmd_hs;
    logic rsp_head;
    logic rsp_hs;

    // Pointer increment that wraps modulo OTS_DEPTH (depth need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (ots_cnt_q == '0);
    assign fifo_full  = (ots_cnt_q == OTS_FULL);
    assign ots_cnt    = ots_cnt_q;

    // State register: grant FSM and its held grant / round-robin history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next-state: lock the grant while the bus stalls, release on handshake
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_cmd_vld && !bus_cmd_rdy) begin
                    state_d = ST_LOCK;
                    gnt_d   = sel;
                end
            end
            ST_LOCK: begin
                if (cmd_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cmd_hs) begin
            last_gnt_d = sel;
        end
    end

    // Output: choose the granted master and pass its command straight to the bus
    always_comb begin
        sel     = 1'b0;
        gnt_act = 1'b0;
        if (state_q == ST_LOCK) begin
            sel     = gnt_q;
            gnt_act = 1'b1;
        end else if (!fifo_full) begin
            if (m0_cmd_vld && m1_cmd_vld) begin
                sel = ~last_gnt_q;
            end else begin
                sel = m1_cmd_vld;
            end
            gnt_act = m0_cmd_vld | m1_cmd_vld;
        end

        bus_cmd_vld   = reset_n & gnt_act & (sel ? m1_cmd_vld : m0_cmd_vld);
        bus_cmd_write = 1'b0;
        bus_cmd_addr  = '0;
        bus_cmd_wdata = '0;
        bus_cmd_wstrb = '0;
        if (bus_cmd_vld) begin
            bus_cmd_write = sel ? m1_cmd_write : m0_cmd_write;
            bus_cmd_addr  = sel ? m1_cmd_addr  : m0_cmd_addr;
            bus_cmd_wdata = sel ? m1_cmd_wdata : m0_cmd_wdata;
            bus_cmd_wstrb = sel ? m1_cmd_wstrb : m0_cmd_wstrb;
        end
        m0_cmd_rdy = bus_cmd_vld & bus_cmd_rdy & ~sel;
        m1_cmd_rdy = bus_cmd_vld & bus_cmd_rdy &  sel;
        cmd_hs     = bus_cmd_vld & bus_cmd_rdy;
    end

    // Response routing: FIFO head picks the destination; empty FIFO swallows orphans
    always_comb begin
        rsp_head     = id_q[rd_ptr_q];
        m0_rsp_vld   = reset_n & bus_rsp_vld & ~fifo_empty & ~rsp_head;
        m1_rsp_vld   = reset_n & bus_rsp_vld & ~fifo_empty &  rsp_head;
        bus_rsp_rdy  = reset_n & (fifo_empty | (rsp_head ? m1_rsp_rdy : m0_rsp_rdy));
        rsp_orphan   = reset_n & bus_rsp_vld & fifo_empty;
        m0_rsp_rdata = reset_n ? bus_rsp_rdata : '0;
        m1_rsp_rdata = reset_n ? bus_rsp_rdata : '0;
        m0_rsp_err   = reset_n & bus_rsp_err;
        m1_rsp_err   = reset_n & bus_rsp_err;
        rsp_hs       = bus_rsp_vld & bus_rsp_rdy & ~fifo_empty;
    end

    // ID FIFO and outstanding counter next values
    always_comb begin
        id_d      = id_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ots_cnt_d = ots_cnt_q;
        if (cmd_hs) begin
            id_d[wr_ptr_q] = sel;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (rsp_hs) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({cmd_hs, rsp_hs})
            2'b10:   ots_cnt_d = ots_cnt_q + 1'b1;
            2'b01:   ots_cnt_d = ots_cnt_q - 1'b1;
            default: ots_cnt_d = ots_cnt_q;
        endcase
    end

    // ID FIFO and outstanding counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ots_cnt_q <= '0;
        end else begin
            id_q      <= id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ots_cnt_q <= ots_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lnrv_biu_arb.sv
// ============================================================================
//  Module      : tb_lnrv_biu_arb
//  Description : Self-checking bench for lnrv_biu_arb; queue-based reference
//                model, directed pinning sequences and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lnrv_biu_arb;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset_n;

    logic        cv [2];
    logic        cw [2];
    logic [31:0] ca [2];
    logic [31:0] cd [2];
    logic [3:0]  cs [2];
    logic        rr [2];

    logic        bus_cmd_rdy;
    logic        bus_rsp_vld;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    wire         m0_cmd_rdy, m1_cmd_rdy, m0_rsp_vld, m1_rsp_vld;
    wire  [31:0] m0_rsp_rdata, m1_rsp_rdata;
    wire         m0_rsp_err, m1_rsp_err;
    wire         bus_cmd_vld, bus_cmd_write, bus_rsp_rdy, rsp_orphan;
    wire  [31:0] bus_cmd_addr, bus_cmd_wdata;
    wire  [3:0]  bus_cmd_wstrb;
    wire  [1:0]  ots_cnt;

    lnrv_biu_arb #(.OTS_DEPTH(DEPTH), .OTS_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_cmd_vld(cv[0]), .m0_cmd_rdy(m0_cmd_rdy), .m0_cmd_write(cw[0]),
        .m0_cmd_addr(ca[0]), .m0_cmd_wdata(cd[0]), .m0_cmd_wstrb(cs[0]),
        .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(rr[0]), .m0_rsp_rdata(m0_rsp_rdata),
        .m0_rsp_err(m0_rsp_err),
        .m1_cmd_vld(cv[1]), .m1_cmd_rdy(m1_cmd_rdy), .m1_cmd_write(cw[1]),
        .m1_cmd_addr(ca[1]), .m1_cmd_wdata(cd[1]), .m1_cmd_wstrb(cs[1]),
        .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(rr[1]), .m1_rsp_rdata(m1_rsp_rdata),
        .m1_rsp_err(m1_rsp_err),
        .bus_cmd_vld(bus_cmd_vld), .bus_cmd_rdy(bus_cmd_rdy),
        .bus_cmd_write(bus_cmd_write), .bus_cmd_addr(bus_cmd_addr),
        .bus_cmd_wdata(bus_cmd_wdata), .bus_cmd_wstrb(bus_cmd_wstrb),
        .bus_rsp_vld(bus_rsp_vld), .bus_rsp_rdy(bus_rsp_rdy),
        .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
        .ots_cnt(ots_cnt), .rsp_orphan(rsp_orphan)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: queue of outstanding requester IDs, round-robin
    // history, and the requester a stalled grant is committed to (-1 = none).
    int idq[$];
    int last_gnt;
    int lock;
    bit hold [2];
    int n_gnt [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the current inputs,
    // then advance the model as the clock edge would.
    task automatic step();
        int  g;
        int  h;
        bit  empty;
        bit  e_rsp_rdy;
        bit  cmd_hs;
        bit  rsp_hs;
        #1;
        g = -1;
        if (lock >= 0) g = lock;
        else if (idq.size() < DEPTH) begin
            if (cv[0] && cv[1]) g = 1 - last_gnt;
            else if (cv[0])     g = 0;
            else if (cv[1])     g = 1;
        end
        chk("ots_cnt", 32'(ots_cnt), 32'(idq.size()));
        chk("bus_cmd_vld", 32'(bus_cmd_vld), 32'(g >= 0 && cv[g]));
        chk("m0_cmd_rdy", 32'(m0_cmd_rdy), 32'(g == 0 && bus_cmd_rdy));
        chk("m1_cmd_rdy", 32'(m1_cmd_rdy), 32'(g == 1 && bus_cmd_rdy));
        if (g >= 0) begin
            chk("bus_cmd_addr",  bus_cmd_addr, ca[g]);
            chk("bus_cmd_wdata", bus_cmd_wdata, cd[g]);
            chk("bus_cmd_wstrb", 32'(bus_cmd_wstrb), 32'(cs[g]));
            chk("bus_cmd_write", 32'(bus_cmd_write), 32'(cw[g]));
        end
        empty     = (idq.size() == 0);
        h         = empty ? -1 : idq[0];
        e_rsp_rdy = empty ? 1'b1 : rr[h];
        chk("m0_rsp_vld", 32'(m0_rsp_vld), 32'(bus_rsp_vld && h == 0));
        chk("m1_rsp_vld", 32'(m1_rsp_vld), 32'(bus_rsp_vld && h == 1));
        chk("rsp_orphan", 32'(rsp_orphan), 32'(bus_rsp_vld && empty));
        if (bus_rsp_vld) begin
            chk("bus_rsp_rdy", 32'(bus_rsp_rdy), 32'(e_rsp_rdy));
            if (h == 0) begin
                chk("m0_rsp_rdata", m0_rsp_rdata, bus_rsp_rdata);
                chk("m0_rsp_err", 32'(m0_rsp_err), 32'(bus_rsp_err));
            end
            if (h == 1) begin
                chk("m1_rsp_rdata", m1_rsp_rdata, bus_rsp_rdata);
                chk("m1_rsp_err", 32'(m1_rsp_err), 32'(bus_rsp_err));
            end
        end
        cmd_hs = (g >= 0) && cv[g] && bus_cmd_rdy;
        rsp_hs = bus_rsp_vld && !empty && e_rsp_rdy;
        if (rsp_hs) void'(idq.pop_front());
        if (cmd_hs) begin
            idq.push_back(g);
            last_gnt = g;
            lock     = -1;
            hold[g]  = 1'b0;
            n_gnt[g]++;
        end else if (g >= 0 && cv[g]) begin
            lock = g;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            cv[i] = 0; cw[i] = 0; ca[i] = '0; cd[i] = '0; cs[i] = '0; rr[i] = 0;
            hold[i] = 0;
        end
        bus_cmd_rdy = 0; bus_rsp_vld = 0; bus_rsp_rdata = '0; bus_rsp_err = 0;
    endtask

    // Assert reset, check the reset-state outputs, release on a later negedge
    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        idq.delete();
        last_gnt = 1;
        lock     = -1;
        #1;
        chk("rst_ots_cnt", 32'(ots_cnt), 32'd0);
        chk("rst_bus_cmd_vld", 32'(bus_cmd_vld), 32'd0);
        chk("rst_cmd_rdy", 32'({m0_cmd_rdy, m1_cmd_rdy}), 32'd0);
        chk("rst_rsp_vld", 32'({m0_rsp_vld, m1_rsp_vld}), 32'd0);
        chk("rst_bus_rsp_rdy", 32'(bus_rsp_rdy), 32'd0);
        chk("rst_orphan", 32'(rsp_orphan), 32'd0);
        chk("rst_bus_cmd_addr", bus_cmd_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [31:0] alt_exp [4];
    logic [31:0] lock_exp [5];

    initial begin
        int p_req;
        int p_rdy;
        int p_rsp;
        reset_n  = 1'b0;
        n_gnt[0] = 0;
        n_gnt[1] = 0;
        do_reset();

        // Both requesting every cycle: grants alternate m0, m1, m0, m1
        alt_exp[0] = 32'h100; alt_exp[1] = 32'h200;
        alt_exp[2] = 32'h100; alt_exp[3] = 32'h200;
        cv[0] = 1; ca[0] = 32'h100; cv[1] = 1; ca[1] = 32'h200;
        bus_cmd_rdy = 1; bus_rsp_vld = 1; rr[0] = 1; rr[1] = 1;
        bus_rsp_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_grant_addr", bus_cmd_addr, alt_exp[i]);
            step();
        end

        // m1 stalled for 3 cycles while m0 joins: grant stays on m1, then m0
        do_reset();
        lock_exp[0] = 32'h200; lock_exp[1] = 32'h200; lock_exp[2] = 32'h200;
        lock_exp[3] = 32'h200; lock_exp[4] = 32'h100;
        cv[1] = 1; ca[1] = 32'h200; ca[0] = 32'h100; bus_rsp_vld = 0;
        for (int i = 0; i < 5; i++) begin
            bus_cmd_rdy = (i >= 3);
            if (i >= 1) cv[0] = 1;
            if (i == 4) cv[1] = 0;
            #1;
            chk("lock_grant_addr", bus_cmd_addr, lock_exp[i]);
            if (i == 3) chk("lock_m1_accept", 32'(m1_cmd_rdy), 32'd1);
            step();
        end

        // Fill to OTS_DEPTH with m0 only, check blocking, then reset mid-flight
        do_reset();
        cv[0] = 1; ca[0] = 32'h40; bus_cmd_rdy = 1;
        step();
        step();
        #1;
        chk("full_ots_cnt", 32'(ots_cnt), 32'd2);
        chk("full_blocks_grant", 32'(bus_cmd_vld), 32'd0);
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_ots_cnt", 32'(ots_cnt), 32'd0);
        chk("midrst_bus_cmd_vld", 32'(bus_cmd_vld), 32'd0);
        do_reset();

        // Randomized traffic under several load profiles
        for (int phase = 0; phase < 3; phase++) begin
            p_req = (phase == 0) ? 40 : (phase == 1) ? 90 : 70;
            p_rdy = (phase == 0) ? 80 : (phase == 1) ? 50 : 30;
            p_rsp = (phase == 0) ? 60 : (phase == 1) ? 80 : 40;
            for (int c = 0; c < 1000; c++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!hold[i] && $urandom_range(0, 99) < p_req) begin
                        hold[i] = 1;
                        cw[i] = 1'($urandom);
                        ca[i] = $urandom;
                        cd[i] = $urandom;
                        cs[i] = 4'($urandom);
                    end
                    cv[i] = hold[i];
                    rr[i] = ($urandom_range(0, 99) < 70);
                end
                bus_cmd_rdy   = ($urandom_range(0, 99) < p_rdy);
                bus_rsp_vld   = ($urandom_range(0, 99) < p_rsp);
                bus_rsp_rdata = $urandom;
                bus_rsp_err   = ($urandom_range(0, 7) == 0);
                step();
            end
        end

        chk("m0_got_grants", 32'(n_gnt[0] > 10), 32'd1);
        chk("m1_got_grants", 32'(n_gnt[1] > 10), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
